intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Memory-mapped interrupt controller; consumes the level/pulse request lines of the
//  on-chip peripherals (timer limit-hit, keys, switches) and raises one INTR to the CPU.
//  Latches edge-triggered pending bits, masks them, picks the highest-priority source,
//  and runs a request/acknowledge/end-of-interrupt handshake with the processor.
//  Sits on the shared ABUS/DBUSI/DBUSO bus; DBUSO is zero when unselected (OR-combined).
// PARAMETERS
//  NSRC      4             number of request inputs (1..16); source 0 = timer
//  IPENDADDR 32'hFFFFF200  pending register (read; write-1-to-clear)
//  IENADDR   32'hFFFFF204  enable mask register (read/write)
//  ICTLADDR  32'hFFFFF208  control/status: bit0 GIE (r/w), bit1 INSVC (read-only)
//  IVECADDR  32'hFFFFF20C  vector: bits[3:0] IID in service; any write = EOI
// PORTS
//  CLK      in   1     system clock, all state on posedge
//  RESET    in   1     asynchronous, active-high reset
//  ABUS     in   32    CPU address bus
//  DBUSI    in   32    CPU write data
//  WE       in   1     write enable, qualifies ABUS/DBUSI this cycle
//  IRQ_IN   in   NSRC  peripheral request lines, synchronous to CLK
//  IACK     in   1     one-cycle CPU acknowledge of INTR
//  DBUSO    out  32    read data; 32'd0 unless a controller address is read (WE=0)
//  INTR     out  1     interrupt request to CPU
// BEHAVIOUR
//  Reset (async): IPEND=0, IEN=0, GIE=0, INSVC=0, IID=0, IRQ_PREV=0, state IDLE,
//   INTR=0; DBUSO combinational, 0 while ABUS unselected.
//  Edge detect: evt[i] = IRQ_IN[i] & ~IRQ_PREV[i]; IRQ_PREV <= IRQ_IN every cycle.
//  IPEND[i] next = evt[i] | (IPEND[i] & ~w1c[i] & ~ackclr[i]); set wins over clear
//   in the same cycle. w1c = DBUSI[NSRC-1:0] on write to IPENDADDR.
//  act = IPEND & IEN; sel = lowest index set in act (index 0 highest priority).
//  FSM (2-bit, registered):
//   IDLE : INTR=0; -> REQ when GIE & |act.
//   REQ  : INTR=1; if IACK: IID<=sel, clear IPEND[sel], INSVC<=1 -> SVC.
//          If act falls to 0 or GIE cleared before IACK -> IDLE (INTR drops next cycle).
//   SVC  : INTR=0; new events still latch into IPEND; no nesting.
//          Write to IVECADDR (EOI): INSVC<=0 -> IDLE; re-request next cycle if act.
//  INTR is a registered decode of state: rises 1 cycle after GIE & |act first true.
//  IACK outside REQ is ignored (no state change). EOI outside SVC ignored.
//  IID captured at IACK edge; later higher-priority events do not change it.
//  Reads: zero-latency combinational; IPEND/IEN zero-extended, ICTL={30'b0,INSVC,GIE},
//   IVEC={28'b0,IID}. Register writes take effect on the WE cycle's posedge.
//  Write to ICTLADDR updates GIE only (DBUSI[0]); INSVC not writable.
//  Unlisted addresses: no effect, DBUSO=0. NSRC<32: upper IPEND/IEN bits read 0.
//  RESET mid-handshake returns to IDLE with all pending cleared; no INTR glitch.
// STRUCTURE
//  Package intr_pkg: address constants, FSM state encoding (IDLE/REQ/SVC), IID width.
//  Sub-module intr_prio_enc: NSRC-bit active vector -> {valid, index}, combinational.
//  Top: edge detect, registers, FSM, bus decode/read mux.
// TESTING
//  IEN=1,GIE=1, pulse IRQ_IN[0] 1 cycle -> INTR=1 next cycle+1; IACK -> IVEC=0,
//   IPEND=0, INSVC=1, INTR=0; write IVEC -> INSVC=0, INTR stays 0.
//  IEN=4'b1111, IRQ_IN=4'b1010 same cycle -> IACK gives IID=1; after EOI INTR
//   re-asserts, second IACK gives IID=3.
//  IEN=0, IRQ_IN[2] pulse -> IPEND=4'b0100, INTR=0; write IEN=4'b0100 -> INTR=1.
//  IRQ_IN[1] held high 10 cycles -> only one pending set; W1C 4'b0010 -> IPEND=0.
//  Event on IRQ_IN[0] same cycle as W1C 4'b0001 -> IPEND[0]=1 (set wins).
//  In REQ clear GIE before IACK -> INTR drops; assert RESET during SVC -> all regs 0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding, vector width.
package intr_pkg;

  localparam logic [31:0] IPENDADDR = 32'hFFFF_F200;
  localparam logic [31:0] IENADDR   = 32'hFFFF_F204;
  localparam logic [31:0] ICTLADDR  = 32'hFFFF_F208;
  localparam logic [31:0] IVECADDR  = 32'hFFFF_F20C;

  localparam int IID_W    = 4;
  localparam int NSRC_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// Bus and handshake signals between the CPU side (master) and the interrupt controller (slave).
interface intr_ctrl_if #(
  parameter int NSRC = 4
);
  logic [31:0]     ABUS;
  logic [31:0]     DBUSI;
  logic [31:0]     DBUSO;
  logic            WE;
  logic            IACK;
  logic            INTR;
  logic [NSRC-1:0] IRQ_IN;

  modport master (
    output ABUS, DBUSI, WE, IACK, IRQ_IN,
    input  DBUSO, INTR
  );

  modport slave (
    input  ABUS, DBUSI, WE, IACK, IRQ_IN,
    output DBUSO, INTR
  );
endinterface

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: lowest set index of the active vector wins.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0]  i_act,
  output logic             o_valid,
  output logic [IID_W-1:0] o_idx
);

  always_comb begin
    o_valid = |i_act;
    o_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_act[i]) o_idx = IID_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable mask,
// fixed priority and a REQ/IACK/EOI handshake driving a single INTR line.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  intr_ctrl_if.slave bus
);

  logic [NSRC-1:0]  r_ipend;
  logic [NSRC-1:0]  r_ien;
  logic [NSRC-1:0]  r_irq_prev;
  logic             r_gie;
  logic             r_insvc;
  logic             r_intr;
  logic [IID_W-1:0] r_iid;
  state_t           r_state;

  logic [NSRC-1:0]  w_evt;
  logic [NSRC-1:0]  w_act;
  logic [NSRC-1:0]  w_w1c;
  logic [NSRC-1:0]  w_ackclr;
  logic             w_valid;
  logic [IID_W-1:0] w_sel;
  logic             w_req_ok;
  logic             w_take;
  logic             w_eoi;
  logic             w_wr_pend;
  logic             w_wr_en;
  logic             w_wr_ctl;
  logic             w_wr_vec;
  logic [31:0]      w_rdata;

  intr_prio_enc #(.NSRC(NSRC)) u_prio (
    .i_act   (w_act),
    .o_valid (w_valid),
    .o_idx   (w_sel)
  );

  assign w_wr_pend = bus.WE && (bus.ABUS == IPENDADDR);
  assign w_wr_en   = bus.WE && (bus.ABUS == IENADDR);
  assign w_wr_ctl  = bus.WE && (bus.ABUS == ICTLADDR);
  assign w_wr_vec  = bus.WE && (bus.ABUS == IVECADDR);

  assign w_evt    = bus.IRQ_IN & ~r_irq_prev;
  assign w_act    = r_ipend & r_ien;
  assign w_w1c    = w_wr_pend ? bus.DBUSI[NSRC-1:0] : '0;
  assign w_req_ok = r_gie && w_valid;
  // A request withdrawn in the same cycle as IACK is not taken.
  assign w_take   = (r_state == ST_REQ) && w_req_ok && bus.IACK;
  assign w_ackclr = w_take ? (NSRC'(1) << w_sel) : '0;
  assign w_eoi    = w_wr_vec && (r_state == ST_SVC);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_irq_prev <= '0;
      r_ipend    <= '0;
      r_ien      <= '0;
      r_gie      <= 1'b0;
    end else begin
      r_irq_prev <= bus.IRQ_IN;
      r_ipend    <= w_evt | (r_ipend & ~w_w1c & ~w_ackclr);
      if (w_wr_en)  r_ien <= bus.DBUSI[NSRC-1:0];
      if (w_wr_ctl) r_gie <= bus.DBUSI[0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_intr  <= 1'b0;
      r_insvc <= 1'b0;
      r_iid   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_ok) begin
            r_state <= ST_REQ;
            r_intr  <= 1'b1;
          end else begin
            r_intr  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (!w_req_ok) begin
            r_state <= ST_IDLE;
            r_intr  <= 1'b0;
          end else if (w_take) begin
            r_state <= ST_SVC;
            r_intr  <= 1'b0;
            r_iid   <= w_sel;
            r_insvc <= 1'b1;
          end
        end
        ST_SVC: begin
          r_intr <= 1'b0;
          if (w_eoi) begin
            r_state <= ST_IDLE;
            r_insvc <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_intr  <= 1'b0;
        end
      endcase
    end
  end

  // Read data must be zero whenever unselected so it can be OR-combined on the bus.
  always_comb begin
    w_rdata = '0;
    if (!bus.WE) begin
      case (bus.ABUS)
        IPENDADDR: w_rdata[NSRC-1:0]  = r_ipend;
        IENADDR:   w_rdata[NSRC-1:0]  = r_ien;
        ICTLADDR:  w_rdata[1:0]       = {r_insvc, r_gie};
        IVECADDR:  w_rdata[IID_W-1:0] = r_iid;
        default:   w_rdata            = '0;
      endcase
    end
  end

  assign bus.DBUSO = w_rdata;
  assign bus.INTR  = r_intr;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed and randomized checks of intr_ctrl against a behavioural model of the
// pending/mask/priority/handshake rules.
module tb_intr_ctrl;
  import intr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  intr_ctrl_if #(.NSRC(4)) bus ();

  intr_ctrl #(.NSRC(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;

  // Model: 0 = quiet, 1 = requesting CPU, 2 = handler running.
  int         m_mode;
  logic [3:0] m_pend, m_en, m_prev, m_iid;
  logic       m_gie, m_insvc;

  function automatic void model_reset();
    m_mode = 0; m_pend = '0; m_en = '0; m_prev = '0; m_iid = '0;
    m_gie = 1'b0; m_insvc = 1'b0;
  endfunction

  function automatic void model_step(input logic we, input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] irq, input logic ack);
    logic [3:0] evt, act, w1c, ackclr;
    int         sel;
    logic       want;
    evt    = irq & ~m_prev;
    act    = m_pend & m_en;
    want   = m_gie && (act != 0);
    w1c    = (we && a == IPENDADDR) ? d[3:0] : 4'd0;
    ackclr = 4'd0;
    sel    = 0;
    for (int i = 3; i >= 0; i--) if (act[i]) sel = i;
    if (m_mode == 0) begin
      if (want) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!want) m_mode = 0;
      else if (ack) begin
        m_iid = 4'(sel); ackclr[sel] = 1'b1; m_insvc = 1'b1; m_mode = 2;
      end
    end else if (we && a == IVECADDR) begin
      m_insvc = 1'b0; m_mode = 0;
    end
    m_pend = evt | (m_pend & ~w1c & ~ackclr);
    if (we && a == IENADDR) m_en = d[3:0];
    if (we && a == ICTLADDR) m_gie = d[0];
    m_prev = irq;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.WE = 1'b0; bus.ABUS = a; #1; v = bus.DBUSO;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    chk({tag, ".intr"}, {31'd0, bus.INTR}, {31'd0, m_mode == 1});
    rd(IPENDADDR, v); chk({tag, ".ipend"}, v, {28'd0, m_pend});
    rd(IENADDR, v);   chk({tag, ".ien"}, v, {28'd0, m_en});
    rd(ICTLADDR, v);  chk({tag, ".ictl"}, v, {30'd0, m_insvc, m_gie});
    rd(IVECADDR, v);  chk({tag, ".ivec"}, v, {28'd0, m_iid});
    rd(32'hFFFF_F210, v); chk({tag, ".unmapped"}, v, 32'd0);
  endtask

  task automatic cyc(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] irq, input logic ack);
    bus.WE = we; bus.ABUS = a; bus.DBUSI = d; bus.IRQ_IN = irq; bus.IACK = ack;
    if (we) begin
      #1; chk({tag, ".wr_dbuso"}, bus.DBUSO, 32'd0);
    end
    @(posedge clk);
    model_step(we, a, d, irq, ack);
    #1;
    bus.WE = 1'b0; bus.IACK = 1'b0;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] irq);
    cyc(tag, 1'b1, a, d, irq, 1'b0);
  endtask

  task automatic idle(input string tag, input logic [3:0] irq);
    cyc(tag, 1'b0, 32'd0, 32'd0, irq, 1'b0);
  endtask

  task automatic ack(input string tag);
    cyc(tag, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
  endtask

  logic [31:0] v;
  logic [31:0] addrs [5];

  initial begin
    addrs = '{IPENDADDR, IENADDR, ICTLADDR, IVECADDR, 32'hFFFF_F210};
    bus.WE = 0; bus.ABUS = 0; bus.DBUSI = 0; bus.IRQ_IN = 0; bus.IACK = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #5 rst = 1'b0;
    check_all("reset");

    // single source, full handshake
    wr("t1_ien", IENADDR, 32'h1, 4'd0);
    wr("t1_gie", ICTLADDR, 32'h1, 4'd0);
    idle("t1_pulse", 4'b0001);
    chk("t1_intr_lo", {31'd0, bus.INTR}, 32'd0);
    idle("t1_wait", 4'b0000);
    chk("t1_intr_hi", {31'd0, bus.INTR}, 32'd1);
    ack("t1_iack");
    rd(IVECADDR, v);  chk("t1_ivec", v, 32'd0);
    rd(ICTLADDR, v);  chk("t1_insvc", v, 32'd3);
    rd(IPENDADDR, v); chk("t1_ipend", v, 32'd0);
    wr("t1_eoi", IVECADDR, 32'd0, 4'd0);
    idle("t1_after", 4'd0);
    chk("t1_intr_stays_lo", {31'd0, bus.INTR}, 32'd0);

    // two simultaneous sources, priority order
    wr("t2_ien", IENADDR, 32'hF, 4'd0);
    idle("t2_pulse", 4'b1010);
    idle("t2_wait", 4'b0000);
    ack("t2_iack1");
    rd(IVECADDR, v); chk("t2_iid1", v, 32'd1);
    wr("t2_eoi1", IVECADDR, 32'd0, 4'd0);
    idle("t2_rereq", 4'd0);
    chk("t2_intr_re", {31'd0, bus.INTR}, 32'd1);
    ack("t2_iack2");
    rd(IVECADDR, v); chk("t2_iid3", v, 32'd3);
    wr("t2_eoi2", IVECADDR, 32'd0, 4'd0);

    // masked source becomes live when enabled
    wr("t3_ien0", IENADDR, 32'h0, 4'd0);
    idle("t3_pulse", 4'b0100);
    idle("t3_wait", 4'b0000);
    rd(IPENDADDR, v); chk("t3_ipend", v, 32'h4);
    wr("t3_ien", IENADDR, 32'h4, 4'd0);
    idle("t3_req", 4'd0);
    chk("t3_intr", {31'd0, bus.INTR}, 32'd1);
    ack("t3_iack");
    wr("t3_eoi", IVECADDR, 32'd0, 4'd0);
    wr("t3_ien_off", IENADDR, 32'h0, 4'd0);

    // held level latches once; W1C clears
    for (int i = 0; i < 10; i++) idle("t4_hold", 4'b0010);
    rd(IPENDADDR, v); chk("t4_once", v, 32'h2);
    wr("t4_w1c", IPENDADDR, 32'h2, 4'b0000);
    rd(IPENDADDR, v); chk("t4_clr", v, 32'h0);

    // set beats clear in the same cycle
    wr("t5_race", IPENDADDR, 32'h1, 4'b0001);
    rd(IPENDADDR, v); chk("t5_setwins", v, 32'h1);

    // GIE withdrawn during REQ, then reset during SVC
    wr("t6_ien", IENADDR, 32'h1, 4'd0);
    idle("t6_req", 4'd0);
    chk("t6_intr_hi", {31'd0, bus.INTR}, 32'd1);
    wr("t6_gie_off", ICTLADDR, 32'h0, 4'd0);
    idle("t6_drop", 4'd0);
    chk("t6_intr_drop", {31'd0, bus.INTR}, 32'd0);
    wr("t6_gie_on", ICTLADDR, 32'h1, 4'd0);
    idle("t6_req2", 4'd0);
    ack("t6_iack");
    rd(ICTLADDR, v); chk("t6_insvc", v, 32'd3);
    rst = 1'b1; #1;
    model_reset();
    check_all("t6_reset");
    #2 rst = 1'b0;

    // randomized traffic
    wr("rnd_ien", IENADDR, 32'hF, 4'd0);
    wr("rnd_gie", ICTLADDR, 32'h1, 4'd0);
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [31:0] a, d;
      we = ($urandom_range(0, 3) == 0);
      a  = addrs[$urandom_range(0, 4)];
      d  = $urandom;
      if (a == ICTLADDR) d = {31'd0, $urandom_range(0, 3) != 0};
      cyc("rnd", we, a, d, 4'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
